// File: rtl/lab3_mealy_decoder.sv
// ---------------------------------------------------------------------------
// lab3_mealy_decoder
//   Receive-side inverse of the Lab3 four-state Mealy encoder. A local copy
//   of the encoder state is advanced using the bits already decoded. Each
//   accepted encoded bit z is turned back into x = z ^ parity(state). The
//   recovered bits are packed LSB-first into WORD_W-bit words.
//
// Ports
//   i_clock       rising-edge clock
//   i_reset       synchronous, active-high reset (highest priority)
//   i_in_valid    i_z_in carries a valid encoded bit this cycle
//   i_z_in        encoded bit (encoder output z)
//   i_sync        resynchronise: tracker to S0, partial word dropped
//   o_x_out       decoded bit (registered, holds between strobes)
//   o_x_valid     1-cycle pulse, o_x_out valid
//   o_word_out    packed decoded word, LSB = first bit received (holds)
//   o_word_valid  1-cycle pulse, o_word_out valid
//   o_state_out   current tracker state (debug)
// ---------------------------------------------------------------------------
module lab3_mealy_decoder #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic              i_z_in,
  input  logic              i_sync,
  output logic              o_x_out,
  output logic              o_x_valid,
  output logic [WORD_W-1:0] o_word_out,
  output logic              o_word_valid,
  output logic [1:0]        o_state_out
);

  localparam int unsigned       CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WORD_W-1:0]  r_shift;

  logic               w_parity;
  logic               w_x;
  state_t             w_next;
  logic [WORD_W-1:0]  w_word;

  // Decode and next-state are both functions of the current tracker state
  // and the incoming z, so x is available in the same cycle as z.
  always_comb begin
    w_parity = (r_state == S0) || (r_state == S3);
    w_x      = i_z_in ^ w_parity;
    w_next   = S0;
    unique case (r_state)
      S0: w_next = w_x ? S2 : S1;
      S1: w_next = w_x ? S3 : S0;
      S2: w_next = w_x ? S3 : S1;
      S3: w_next = w_x ? S2 : S0;
    endcase
    // Full word including the bit being accepted now, so the last bit and
    // the word load share one edge with no extra pipeline stage.
    w_word          = r_shift;
    w_word[r_count] = w_x;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S0;
      r_count      <= '0;
      r_shift      <= '0;
      o_x_out      <= 1'b0;
      o_x_valid    <= 1'b0;
      o_word_out   <= '0;
      o_word_valid <= 1'b0;
    end else if (i_sync) begin
      r_state      <= S0;
      r_count      <= '0;
      r_shift      <= '0;
      o_x_valid    <= 1'b0;
      o_word_valid <= 1'b0;
    end else if (i_in_valid) begin
      r_state   <= w_next;
      o_x_out   <= w_x;
      o_x_valid <= 1'b1;
      if (r_count == LAST) begin
        r_count      <= '0;
        r_shift      <= '0;
        o_word_out   <= w_word;
        o_word_valid <= 1'b1;
      end else begin
        r_count      <= r_count + 1'b1;
        r_shift      <= w_word;
        o_word_valid <= 1'b0;
      end
    end else begin
      o_x_valid    <= 1'b0;
      o_word_valid <= 1'b0;
    end
  end

  assign o_state_out = r_state;

endmodule

// File: tb/tb_lab3_mealy_decoder.sv
// ---------------------------------------------------------------------------
// tb_lab3_mealy_decoder
//   Directed, table-driven bench for lab3_mealy_decoder (WORD_W = 8).
//   Each table row is the inputs for one clock plus the outputs expected
//   just after that edge. A hand-written sequence covers idle gaps.
// ---------------------------------------------------------------------------
module tb_lab3_mealy_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       z_in;
  logic       sync;
  logic       x_out;
  logic       x_valid;
  logic [7:0] word_out;
  logic       word_valid;
  logic [1:0] state_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  lab3_mealy_decoder #(.WORD_W(8)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_in_valid   (in_valid),
    .i_z_in       (z_in),
    .i_sync       (sync),
    .o_x_out      (x_out),
    .o_x_valid    (x_valid),
    .o_word_out   (word_out),
    .o_word_valid (word_valid),
    .o_state_out  (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       rst;
    logic       sync;
    logic       iv;
    logic       z;
    logic       ex;
    logic       exv;
    logic [7:0] ew;
    logic       ewv;
    logic [1:0] est;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic r, input logic s,
                     input logic iv, input logic z, input logic ex,
                     input logic exv, input logic [7:0] ew,
                     input logic ewv, input logic [1:0] est);
    vec_t v;
    v.tag = tag; v.rst = r; v.sync = s; v.iv = iv; v.z = z;
    v.ex = ex; v.exv = exv; v.ew = ew; v.ewv = ewv; v.est = est;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ex, input logic exv,
                           input logic [7:0] ew, input logic ewv,
                           input logic [1:0] est);
    check({tag, ".x_out"},      32'(x_out),      32'(ex));
    check({tag, ".x_valid"},    32'(x_valid),    32'(exv));
    check({tag, ".word_out"},   32'(word_out),   32'(ew));
    check({tag, ".word_valid"}, 32'(word_valid), 32'(ewv));
    check({tag, ".state_out"},  32'(state_out),  32'(est));
  endtask

  task automatic step(input logic r, input logic s, input logic iv,
                      input logic z);
    rst = r; sync = s; in_valid = iv; z_in = z;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; in_valid = 1'b0; z_in = 1'b0;

    // T1: reset held two clocks with in_valid high
    add("T1r0", 1,0,1,1, 0,0,8'h00,0,2'd0);
    add("T1r1", 1,0,1,0, 0,0,8'h00,0,2'd0);
    add("T1idle", 0,0,0,0, 0,0,8'h00,0,2'd0);
    // T2: z=0,0,1,0,0,0 -> x=1,0,1,1,0,0 ; states S2,S1,S3,S2,S1,S0
    add("T2b0", 0,0,1,0, 1,1,8'h00,0,2'd2);
    add("T2b1", 0,0,1,0, 0,1,8'h00,0,2'd1);
    add("T2b2", 0,0,1,1, 1,1,8'h00,0,2'd3);
    add("T2b3", 0,0,1,0, 1,1,8'h00,0,2'd2);
    add("T2b4", 0,0,1,0, 0,1,8'h00,0,2'd1);
    add("T2b5", 0,0,1,0, 0,1,8'h00,0,2'd0);
    // sync with in_valid=1: input bit ignored, partial word dropped
    add("T2sync", 0,1,1,0, 0,0,8'h00,0,2'd0);
    // T3: z=1,0,... from S0 decodes to all zeros, toggling S1/S0
    for (int i = 0; i < 8; i++)
      add($sformatf("T3b%0d", i), 0,0,1,((i%2)==0), 0,1,8'h00,(i==7),
          ((i%2)==0) ? 2'd1 : 2'd0);
    add("T3idle", 0,0,0,1, 0,0,8'h00,0,2'd0);
    // T4a: z=0,1,... from S0 decodes to all ones, tracker S2/S3, ends S3
    for (int i = 0; i < 8; i++)
      add($sformatf("T4a%0d", i), 0,0,1,((i%2)==1), 1,1,
          (i==7) ? 8'hFF : 8'h00, (i==7), ((i%2)==0) ? 2'd2 : 2'd3);
    // T4b back-to-back: from S3, z=1,0,1,0,... -> x=0,1,1,1,1,1,1,1 = 8'hFE
    add("T4b0", 0,0,1,1, 0,1,8'hFF,0,2'd0);
    for (int i = 1; i < 8; i++)
      add($sformatf("T4b%0d", i), 0,0,1,((i%2)==0), 1,1,
          (i==7) ? 8'hFE : 8'hFF, (i==7), ((i%2)==1) ? 2'd2 : 2'd3);
    add("T4idle", 0,0,0,0, 1,0,8'hFE,0,2'd2);
    // T6 sync: realign, 5 bits of T3, sync, T2 bits, then 2 more bits
    add("T6s_sync0", 0,1,0,0, 1,0,8'hFE,0,2'd0);
    for (int i = 0; i < 5; i++)
      add($sformatf("T6s_p%0d", i), 0,0,1,((i%2)==0), 0,1,8'hFE,0,
          ((i%2)==0) ? 2'd1 : 2'd0);
    add("T6s_sync1", 0,1,0,0, 0,0,8'hFE,0,2'd0);
    add("T6s_b0", 0,0,1,0, 1,1,8'hFE,0,2'd2);
    add("T6s_b1", 0,0,1,0, 0,1,8'hFE,0,2'd1);
    add("T6s_b2", 0,0,1,1, 1,1,8'hFE,0,2'd3);
    add("T6s_b3", 0,0,1,0, 1,1,8'hFE,0,2'd2);
    add("T6s_b4", 0,0,1,0, 0,1,8'hFE,0,2'd1);
    add("T6s_b5", 0,0,1,0, 0,1,8'hFE,0,2'd0);
    // bits 6,7 from S0: z=0 -> x=1 (S2), z=1 -> x=1 (S3); word 1011_0011 LSB first
    add("T6s_b6", 0,0,1,0, 1,1,8'hFE,0,2'd2);
    add("T6s_b7", 0,0,1,1, 1,1,8'hCD,1,2'd3);
    // T6 reset: same sequence with reset in place of sync
    add("T6r_rst0", 1,0,0,0, 0,0,8'h00,0,2'd0);
    for (int i = 0; i < 5; i++)
      add($sformatf("T6r_p%0d", i), 0,0,1,((i%2)==0), 0,1,8'h00,0,
          ((i%2)==0) ? 2'd1 : 2'd0);
    add("T6r_rst1", 1,0,1,1, 0,0,8'h00,0,2'd0);
    add("T6r_b0", 0,0,1,0, 1,1,8'h00,0,2'd2);
    add("T6r_b1", 0,0,1,0, 0,1,8'h00,0,2'd1);
    add("T6r_b2", 0,0,1,1, 1,1,8'h00,0,2'd3);
    add("T6r_b3", 0,0,1,0, 1,1,8'h00,0,2'd2);
    add("T6r_b4", 0,0,1,0, 0,1,8'h00,0,2'd1);
    add("T6r_b5", 0,0,1,0, 0,1,8'h00,0,2'd0);
    add("T6r_b6", 0,0,1,0, 1,1,8'h00,0,2'd2);
    add("T6r_b7", 0,0,1,1, 1,1,8'hCD,1,2'd3);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].sync, vecs[i].iv, vecs[i].z);
      check_all(vecs[i].tag, vecs[i].ex, vecs[i].exv, vecs[i].ew,
                vecs[i].ewv, vecs[i].est);
    end

    // T5: T3 pattern with 0-3 idle cycles before each bit; word_out holds
    // 8'hCD and x_out holds 1 until the first valid bit lands.
    step(0, 1, 0, 0);
    check_all("T5sync", 1'b1, 1'b0, 8'hCD, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      automatic int unsigned gap = $urandom_range(0, 3);
      automatic logic        xh  = (i == 0) ? 1'b1 : 1'b0;
      automatic logic [1:0]  sh  = ((i % 2) == 0) ? 2'd0 : 2'd1;
      for (int g = 0; g < int'(gap); g++) begin
        step(0, 0, 0, $urandom_range(0, 1) == 1);
        check_all($sformatf("T5gap%0d_%0d", i, g), xh, 1'b0, 8'hCD, 1'b0, sh);
      end
      step(0, 0, 1, (i % 2) == 0);
      check_all($sformatf("T5b%0d", i), 1'b0, 1'b1,
                (i == 7) ? 8'h00 : 8'hCD, i == 7,
                ((i % 2) == 0) ? 2'd1 : 2'd0);
    end
    step(0, 0, 0, 0);
    check_all("T5idle", 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
